arrival_light_bank: RTL and testbench

ARRIVAL_LIGHT_BANK -- requirements
Module: arrival_light_bank

---
 rtl/arrival_pkg.sv | 15 +
 rtl/arrival_channel.sv | 113 +++++++++++
 rtl/arrival_light_bank.sv | 53 +++++
 tb/tb_arrival_light_bank.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/arrival_pkg.sv
// Shared state encoding and default parameters for the arrival light bank.
// Optional blink of the light while counting is enabled by defining ARRIVAL_BLINK_EN.
package arrival_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COUNT   = 2'd1,
      ARRIVED = 2'd2
   } arr_state_t;

   localparam int DEFAULT_N_CH        = 4;
   localparam int DEFAULT_HOLD_CYCLES = 32;
   localparam int DEFAULT_BLINK_DIV   = 4;

endpackage

// File: rtl/arrival_channel.sv
// One arrival channel: switch hold-time qualifier, arrival light/strobe and sticky pending flag.
// Defining ARRIVAL_BLINK_EN makes the light blink with a BLINK_DIV half-period while counting.
module arrival_channel
   import arrival_pkg::*;
#(
   parameter int HOLD_CYCLES = DEFAULT_HOLD_CYCLES,
   parameter int BLINK_DIV   = DEFAULT_BLINK_DIV
) (
   input  logic clk,
   input  logic reset,
   input  logic arr_sw,
   input  logic ack,
   output logic arr_li,
   output logic arr_pulse,
   output logic arr_pend,
   output logic counting
);

   localparam int CW = $clog2(HOLD_CYCLES + 1);
   localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD_CYCLES - 1);

   if (HOLD_CYCLES < 1 || HOLD_CYCLES > 65535) begin : g_bad_hold
      $error("arrival_channel: HOLD_CYCLES out of range");
   end
   if (BLINK_DIV < 1) begin : g_bad_blink
      $error("arrival_channel: BLINK_DIV must be at least 1");
   end

   arr_state_t    state;
   logic [CW-1:0] count;
   logic          arrive;

`ifdef ARRIVAL_BLINK_EN
   localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
   localparam logic [BW-1:0] BLINK_LOAD = BW'(BLINK_DIV - 1);
   logic [BW-1:0] blink_cnt;
`endif

   // The qualifying edge: switch still high and the hold has fully elapsed.
   assign arrive = (state == COUNT) && arr_sw && (count == '0);

   // Channel FSM; every output is registered alongside the state.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         count     <= '0;
         arr_li    <= 1'b0;
         arr_pulse <= 1'b0;
         arr_pend  <= 1'b0;
         counting  <= 1'b0;
`ifdef ARRIVAL_BLINK_EN
         blink_cnt <= '0;
`endif
      end else begin
         arr_pulse <= 1'b0;
         arr_pend  <= arrive | (arr_pend & ~ack);
         case (state)
            IDLE: begin
               arr_li <= 1'b0;
               if (arr_sw) begin
                  state    <= COUNT;
                  count    <= HOLD_LOAD;
                  counting <= 1'b1;
`ifdef ARRIVAL_BLINK_EN
                  blink_cnt <= BLINK_LOAD;
`endif
               end else begin
                  counting <= 1'b0;
               end
            end
            COUNT: begin
               if (!arr_sw) begin
                  state    <= IDLE;
                  counting <= 1'b0;
                  arr_li   <= 1'b0;
               end else if (count != '0) begin
                  count <= count - 1'b1;
`ifdef ARRIVAL_BLINK_EN
                  if (blink_cnt == '0) begin
                     arr_li    <= ~arr_li;
                     blink_cnt <= BLINK_LOAD;
                  end else begin
                     blink_cnt <= blink_cnt - 1'b1;
                  end
`else
                  arr_li <= 1'b0;
`endif
               end else begin
                  state     <= ARRIVED;
                  counting  <= 1'b0;
                  arr_li    <= 1'b1;
                  arr_pulse <= 1'b1;
               end
            end
            ARRIVED: begin
               counting <= 1'b0;
               if (!arr_sw) begin
                  state  <= IDLE;
                  arr_li <= 1'b0;
               end else begin
                  arr_li <= 1'b1;
               end
            end
            default: begin
               state    <= IDLE;
               arr_li   <= 1'b0;
               counting <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: rtl/arrival_light_bank.sv
// Bank of N_CH independent arrival channels with a lowest-index pending encoder.
// Define ARRIVAL_BLINK_EN to enable blinking of each light during its hold count.
module arrival_light_bank
   import arrival_pkg::*;
#(
   parameter int N_CH        = DEFAULT_N_CH,
   parameter int HOLD_CYCLES = DEFAULT_HOLD_CYCLES,
   parameter int BLINK_DIV   = DEFAULT_BLINK_DIV,
   localparam int FW         = (N_CH > 1) ? $clog2(N_CH) : 1
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [N_CH-1:0] arr_sw,
   input  logic [N_CH-1:0] ack,
   output logic [N_CH-1:0] arr_li,
   output logic [N_CH-1:0] arr_pulse,
   output logic [N_CH-1:0] arr_pend,
   output logic [N_CH-1:0] counting,
   output logic            any_arr,
   output logic [FW-1:0]   first_ch
);

   if (N_CH < 1 || N_CH > 16) begin : g_bad_nch
      $error("arrival_light_bank: N_CH out of range");
   end

   for (genvar g = 0; g < N_CH; g++) begin : g_ch
      arrival_channel #(
         .HOLD_CYCLES(HOLD_CYCLES),
         .BLINK_DIV  (BLINK_DIV)
      ) u_ch (
         .clk      (clk),
         .reset    (reset),
         .arr_sw   (arr_sw[g]),
         .ack      (ack[g]),
         .arr_li   (arr_li[g]),
         .arr_pulse(arr_pulse[g]),
         .arr_pend (arr_pend[g]),
         .counting (counting[g])
      );
   end

   assign any_arr = |arr_pend;

   // Scan from the top down so the lowest pending index wins.
   always_comb begin
      first_ch = '0;
      for (int i = N_CH - 1; i >= 0; i--) begin
         if (arr_pend[i]) first_ch = FW'(i);
      end
   end

endmodule

// File: tb/tb_arrival_light_bank.sv
// Scoreboard bench for arrival_light_bank against a streak-counting reference model.
// Compile with ARRIVAL_BLINK_EN defined to check the blinking variant.
module tb_arrival_light_bank;

   localparam int N_CH        = 4;
   localparam int HOLD_CYCLES = 4;
   localparam int BLINK_DIV   = 2;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] arr_sw;
   logic [3:0] ack;
   logic [3:0] arr_li;
   logic [3:0] arr_pulse;
   logic [3:0] arr_pend;
   logic [3:0] counting;
   logic       any_arr;
   logic [1:0] first_ch;

   typedef struct packed {
      logic [3:0] li;
      logic [3:0] pulse;
      logic [3:0] pend;
      logic [3:0] cnt;
      logic       any;
      logic [1:0] first;
   } exp_t;

   exp_t expQ[$];
   int   streak[N_CH];
   bit   pendModel[N_CH];
   int   checks   = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   arrival_light_bank #(
      .N_CH       (N_CH),
      .HOLD_CYCLES(HOLD_CYCLES),
      .BLINK_DIV  (BLINK_DIV)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .arr_sw   (arr_sw),
      .ack      (ack),
      .arr_li   (arr_li),
      .arr_pulse(arr_pulse),
      .arr_pend (arr_pend),
      .counting (counting),
      .any_arr  (any_arr),
      .first_ch (first_ch)
   );

   // Drive one cycle of inputs and queue what the outputs must be after the next edge.
   task automatic applyStimulus(input logic [3:0] sw, input logic [3:0] ak, input logic rst);
      exp_t e;
      @(negedge clk);
      arr_sw = sw;
      ack    = ak;
      reset  = rst;
      e = '0;
      for (int ch = 0; ch < N_CH; ch++) begin
         if (rst) begin
            streak[ch]    = 0;
            pendModel[ch] = 1'b0;
         end else begin
            if (sw[ch]) streak[ch] = (streak[ch] < 1000) ? streak[ch] + 1 : streak[ch];
            else        streak[ch] = 0;
            e.pulse[ch] = (streak[ch] == HOLD_CYCLES + 1);
            e.cnt[ch]   = (streak[ch] >= 1) && (streak[ch] <= HOLD_CYCLES);
            if (streak[ch] > HOLD_CYCLES) e.li[ch] = 1'b1;
`ifdef ARRIVAL_BLINK_EN
            else if (streak[ch] >= 1) e.li[ch] = (((streak[ch] - 1) / BLINK_DIV) % 2) == 1;
`endif
            pendModel[ch] = e.pulse[ch] || (pendModel[ch] && !ak[ch]);
         end
         e.pend[ch] = pendModel[ch];
      end
      e.any = |e.pend;
      for (int ch = N_CH - 1; ch >= 0; ch--) if (e.pend[ch]) e.first = 2'(ch);
      expQ.push_back(e);
   endtask

   task automatic compareField(input string name, input logic [3:0] act, input logic [3:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("[TB] FAIL %s at %0t: got %b expected %b", name, $time, act, req);
      end
   endtask

   task automatic checkOutput(input exp_t e);
      compareField("arr_li",    arr_li,          e.li);
      compareField("arr_pulse", arr_pulse,       e.pulse);
      compareField("arr_pend",  arr_pend,        e.pend);
      compareField("counting",  counting,        e.cnt);
      compareField("any_arr",   {3'b0, any_arr}, {3'b0, e.any});
      compareField("first_ch",  {2'b0, first_ch}, {2'b0, e.first});
   endtask

   // Monitor: one expectation per clock edge, sampled just after the edge settles.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #2;
         if (expQ.size() > 0) begin
            e = expQ.pop_front();
            checkOutput(e);
         end
      end
   end

   task automatic holdFor(input int n, input logic [3:0] sw, input logic [3:0] ak, input logic rst);
      for (int i = 0; i < n; i++) applyStimulus(sw, ak, rst);
   endtask

   initial begin
      logic [3:0] rsw;
      logic [3:0] rack;
      reset  = 1'b1;
      arr_sw = '0;
      ack    = '0;
      for (int ch = 0; ch < N_CH; ch++) begin
         streak[ch]    = 0;
         pendModel[ch] = 1'b0;
      end

      holdFor(3, 4'b0000, 4'b0000, 1'b1);
      holdFor(2, 4'b0000, 4'b0000, 1'b0);

      // Single arrival, release in ARRIVED, then acknowledge.
      holdFor(7, 4'b0001, 4'b0000, 1'b0);
      holdFor(3, 4'b0000, 4'b0000, 1'b0);
      holdFor(1, 4'b0000, 4'b0001, 1'b0);
      holdFor(1, 4'b0000, 4'b0001, 1'b0);

      // Aborted hold then a full hold.
      holdFor(3, 4'b0010, 4'b0000, 1'b0);
      holdFor(1, 4'b0000, 4'b0000, 1'b0);
      holdFor(6, 4'b0010, 4'b0000, 1'b0);
      holdFor(2, 4'b0000, 4'b0010, 1'b0);

      // Simultaneous arrivals, acks, and ack colliding with a fresh arrival.
      holdFor(6, 4'b1100, 4'b0000, 1'b0);
      holdFor(1, 4'b1100, 4'b0100, 1'b0);
      holdFor(1, 4'b0100, 4'b0000, 1'b0);
      holdFor(4, 4'b1100, 4'b0000, 1'b0);
      holdFor(1, 4'b1100, 4'b1000, 1'b0);
      holdFor(2, 4'b0000, 4'b0000, 1'b0);

      // Reset in the middle of a hold count.
      holdFor(3, 4'b0001, 4'b0000, 1'b0);
      holdFor(1, 4'b0001, 4'b0000, 1'b1);
      holdFor(7, 4'b0001, 4'b0000, 1'b0);
      holdFor(1, 4'b0000, 4'b1111, 1'b0);

      rsw = '0;
      for (int cyc = 0; cyc < 500; cyc++) begin
         for (int ch = 0; ch < N_CH; ch++) begin
            if ($urandom_range(0, 7) == 0) rsw[ch] = ~rsw[ch];
         end
         rack = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
         applyStimulus(rsw, rack, $urandom_range(0, 99) == 0);
      end
      holdFor(2, 4'b0000, 4'b0000, 1'b0);

      for (int i = 0; i < 10 && expQ.size() > 0; i++) @(posedge clk);
      #5;
      checks++;
      if (expQ.size() != 0) begin
         failures++;
         $display("[TB] FAIL drain: %0d expectations left, expected 0", expQ.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "[TB] watchdog");
   end

endmodule
